// File: rtl/status_led_ctrl_if.sv
// LED controller bundle: per-channel mode/event in, LED drive and shared tick out.
// Free-running, no backpressure; the slave modport is the controller side.
interface status_led_ctrl_if #(
    parameter int CH = 4
);
    logic [3*CH-1:0] mode;
    logic [CH-1:0]   evt;
    logic [CH-1:0]   led;
    logic            tick;

    modport master (output mode, output evt, input led, input tick);
    modport slave  (input mode, input evt, output led, output tick);
endinterface

// File: rtl/status_led_ctrl.sv
// Multi-channel status LED driver on a shared 1 ms tick and phase; mode/event to LED is 1 cycle.
// Free-running, no backpressure: events are single-cycle strobes and are never stalled.
module status_led_ctrl #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 1000,
    parameter int CH              = 4,
    parameter int BLINK_PERIOD_MS = 1000,
    parameter int FLASH_MS        = 50,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    status_led_ctrl_if.slave io_led
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int P   = BLINK_PERIOD_MS;
    localparam int PCW = $clog2(DIV);
    localparam int PHW = $clog2(P);
    localparam int FCW = $clog2(FLASH_MS + 1);

    localparam logic [PCW-1:0] PC_MAX     = PCW'(DIV - 1);
    localparam logic [PHW-1:0] PH_MAX     = PHW'(P - 1);
    localparam logic [PHW-1:0] PH_HALF    = PHW'(P / 2);
    localparam logic [PHW-1:0] PH_QUART   = PHW'(P / 4);
    localparam logic [PHW-1:0] PH_EIGHTH  = PHW'(P / 8);
    localparam logic [PHW-1:0] PH_3EIGHTH = PHW'(3 * P / 8);
    localparam logic [FCW-1:0] FC_LOAD    = FCW'(FLASH_MS);

    localparam logic [2:0] M_OFF   = 3'd0;
    localparam logic [2:0] M_ON    = 3'd1;
    localparam logic [2:0] M_SLOW  = 3'd2;
    localparam logic [2:0] M_FAST  = 3'd3;
    localparam logic [2:0] M_HEART = 3'd4;
    localparam logic [2:0] M_FLASH = 3'd5;

    logic [PCW-1:0] r_pc;
    logic           r_tick;
    logic [PHW-1:0] r_ph;
    logic [FCW-1:0] r_fc     [CH];
    logic [FCW-1:0] w_fc_nxt [CH];
    logic [CH-1:0]  w_on;
    logic [CH-1:0]  r_led;
    logic           w_slow;
    logic           w_fast;
    logic           w_heart;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc   <= '0;
            r_tick <= 1'b0;
            r_ph   <= '0;
        end else begin
            r_pc   <= (r_pc == PC_MAX) ? '0 : r_pc + 1'b1;
            r_tick <= (r_pc == PC_MAX);
            if (r_tick) begin
                r_ph <= (r_ph == PH_MAX) ? '0 : r_ph + 1'b1;
            end
        end
    end

    always_comb begin
        w_slow  = (r_ph < PH_HALF);
        w_fast  = ((r_ph % PH_QUART) < PH_EIGHTH);
        w_heart = (r_ph < PH_EIGHTH) || ((r_ph >= PH_QUART) && (r_ph < PH_3EIGHTH));
    end

    // Flash channels light from the next-state counter so an event shows on the very next edge.
    always_comb begin
        logic [2:0] m;
        for (int i = 0; i < CH; i++) begin
            m           = io_led.mode[3*i +: 3];
            w_fc_nxt[i] = '0;
            w_on[i]     = 1'b0;
            case (m)
                M_OFF:   w_on[i] = 1'b0;
                M_ON:    w_on[i] = 1'b1;
                M_SLOW:  w_on[i] = w_slow;
                M_FAST:  w_on[i] = w_fast;
                M_HEART: w_on[i] = w_heart;
                M_FLASH: begin
                    if (io_led.evt[i]) begin
                        w_fc_nxt[i] = FC_LOAD;
                    end else if (r_tick && (r_fc[i] != '0)) begin
                        w_fc_nxt[i] = r_fc[i] - 1'b1;
                    end else begin
                        w_fc_nxt[i] = r_fc[i];
                    end
                    w_on[i] = (w_fc_nxt[i] != '0);
                end
                default: w_on[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_fc[i] <= '0;
            end
            r_led <= {CH{ACTIVE_LOW}};
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_fc[i] <= w_fc_nxt[i];
            end
            r_led <= w_on ^ {CH{ACTIVE_LOW}};
        end
    end

    assign io_led.led  = r_led;
    assign io_led.tick = r_tick;
endmodule

// File: tb/tb_status_led_ctrl.sv
// Directed bench for status_led_ctrl: DIV=10, P=16, FLASH_MS=5, one active-high and one active-low instance.
module tb_status_led_ctrl;
    localparam int CH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   n     = 0;
    int   c0    = 0;
    int   c1    = 0;
    int   c2    = 0;

    status_led_ctrl_if #(.CH(CH)) bus ();
    status_led_ctrl_if #(.CH(CH)) bus_al ();

    status_led_ctrl #(
        .CLK_HZ(10_000), .TICK_HZ(1000), .CH(CH),
        .BLINK_PERIOD_MS(16), .FLASH_MS(5), .ACTIVE_LOW(1'b0)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .io_led(bus)
    );

    status_led_ctrl #(
        .CLK_HZ(10_000), .TICK_HZ(1000), .CH(CH),
        .BLINK_PERIOD_MS(16), .FLASH_MS(5), .ACTIVE_LOW(1'b1)
    ) u_dut_al (
        .i_clk(clk), .i_rst_n(rst_n), .io_led(bus_al)
    );

    always #5 clk = ~clk;

    // One rising edge, then park on the falling edge for sampling and driving.
    task automatic step();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic go(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 10000) begin
            step();
            guard++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    initial begin
        bus.mode    = {4{3'd1}};
        bus.evt     = '0;
        bus_al.mode = {4{3'd1}};
        bus_al.evt  = '0;
        rst_n       = 1'b0;

        // Reset and tick cadence
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_led", 32'(bus.led), 32'h0);
        chk("rst_tick", 32'(bus.tick), 32'h0);
        chk("rst_led_al", 32'(bus_al.led), 32'hF);
        rst_n = 1'b1;
        n     = 0;
        go(1);
        chk("rel_led", 32'(bus.led), 32'hF);
        chk("rel_led_al", 32'(bus_al.led), 32'h0);
        go(9);
        chk("tick_pre", 32'(bus.tick), 32'h0);
        go(10);
        chk("tick_first", 32'(bus.tick), 32'h1);
        go(11);
        chk("tick_one_cycle", 32'(bus.tick), 32'h0);
        go(19);
        chk("tick_gap", 32'(bus.tick), 32'h0);
        go(20);
        chk("tick_second", 32'(bus.tick), 32'h1);

        // Blink modes: ch0 SLOW, ch1 FAST, ch2 HEART, ch3 OFF
        rst_n    = 1'b0;
        bus.mode = {3'd0, 3'd4, 3'd3, 3'd2};
        step();
        step();
        chk("blink_rst", 32'(bus.led), 32'h0);
        rst_n = 1'b1;
        n     = 0;
        for (int k = 1; k <= 162; k++) begin
            step();
            if (k >= 2 && k <= 161) begin
                c0 += int'(bus.led[0]);
                c1 += int'(bus.led[1]);
                c2 += int'(bus.led[2]);
            end
            case (k)
                1:   chk("blink_ph0", 32'(bus.led), 32'h7);
                22:  chk("blink_ph2", 32'(bus.led), 32'h1);
                42:  chk("blink_ph4", 32'(bus.led), 32'h7);
                62:  chk("blink_ph6", 32'(bus.led), 32'h1);
                82:  chk("blink_ph8", 32'(bus.led), 32'h2);
                161: chk("blink_ph15", 32'(bus.led), 32'h0);
                162: chk("blink_wrap", 32'(bus.led), 32'h7);
                default: ;
            endcase
        end
        chk("slow_high_cnt", 32'(c0), 32'd80);
        chk("fast_high_cnt", 32'(c1), 32'd80);
        chk("heart_high_cnt", 32'(c2), 32'd40);

        // Reset mid-blink, phase restarts from zero
        go(212);
        rst_n = 1'b0;
        step();
        chk("midrst_led", 32'(bus.led), 32'h0);
        chk("midrst_led_al", 32'(bus_al.led), 32'hF);
        chk("midrst_tick", 32'(bus.tick), 32'h0);
        step();
        rst_n = 1'b1;
        n     = 0;
        go(1);
        chk("midrel_led", 32'(bus.led), 32'h7);
        chk("al_on_dark", 32'(bus_al.led), 32'h0);
        go(9);
        chk("midrel_tick_pre", 32'(bus.tick), 32'h0);
        go(10);
        chk("midrel_tick", 32'(bus.tick), 32'h1);
        go(21);
        chk("midrel_ph1", 32'(bus.led), 32'h7);
        go(22);
        chk("midrel_ph2", 32'(bus.led), 32'h1);

        // Flash: ch3 FLASH, ch2 reserved 7, ch1 OFF, ch0 SLOW
        rst_n    = 1'b0;
        bus.mode = {3'd5, 3'd7, 3'd0, 3'd2};
        step();
        step();
        rst_n = 1'b1;
        n     = 0;
        go(1);
        chk("mode7_dark", 32'(bus.led), 32'h1);
        go(3);
        bus.evt = 4'b1001;
        go(4);
        chk("flash_on", 32'(bus.led), 32'h9);
        bus.evt = '0;
        go(50);
        chk("flash_last", 32'(bus.led), 32'h9);
        go(51);
        chk("flash_end", 32'(bus.led), 32'h1);
        go(52);
        bus.evt[3] = 1'b1;
        go(53);
        chk("flash2_on", 32'(bus.led[3]), 32'h1);
        bus.evt = '0;
        go(80);
        chk("tick_at_retrig", 32'(bus.tick), 32'h1);
        bus.evt[3] = 1'b1;
        go(81);
        bus.evt = '0;
        go(100);
        bus.evt[0] = 1'b1;
        go(101);
        chk("slow_evt_ignored", 32'(bus.led[0]), 32'h0);
        bus.evt = '0;
        go(102);
        chk("slow_evt_after", 32'(bus.led[0]), 32'h0);
        go(121);
        chk("retrig_load_wins", 32'(bus.led[3]), 32'h1);
        go(130);
        chk("retrig_last", 32'(bus.led[3]), 32'h1);
        go(131);
        chk("retrig_end", 32'(bus.led[3]), 32'h0);

        // FLASH -> OFF mid-flash, then back to FLASH
        go(132);
        bus.evt[3] = 1'b1;
        go(133);
        bus.evt = '0;
        chk("flash3_on", 32'(bus.led[3]), 32'h1);
        go(135);
        bus.mode[11:9] = 3'd0;
        go(136);
        chk("flash_to_off", 32'(bus.led[3]), 32'h0);
        bus.evt[3] = 1'b1;
        go(137);
        chk("off_evt_ignored", 32'(bus.led[3]), 32'h0);
        bus.evt        = '0;
        bus.mode[11:9] = 3'd5;
        go(140);
        chk("rearm_dark", 32'(bus.led[3]), 32'h0);

        // Event held high keeps the flash lit
        go(141);
        bus.evt[3] = 1'b1;
        go(142);
        chk("hold_on", 32'(bus.led[3]), 32'h1);
        go(230);
        chk("hold_long", 32'(bus.led[3]), 32'h1);
        bus.evt = '0;
        go(270);
        chk("hold_release_last", 32'(bus.led[3]), 32'h1);
        go(271);
        chk("hold_release_end", 32'(bus.led[3]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/status_led_ctrl.md
# status_led_ctrl

Parametrised multi-channel status LED driver, next generation of the single fixed-rate live LED blinker. It derives a shared 1 ms tick from the board clock. It drives CH LED outputs, each independently programmable to off, on, slow blink, fast blink, heartbeat or event-triggered flash. All blinking channels share one phase counter, so they are mutually synchronised. It sits at top level next to the pin assignments and is fed by the relay/status logic.

## Interface
- CLK_HZ, 50_000_000: input clock frequency in Hz.
- TICK_HZ, 1000: tick rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- CH, 4: number of LED channels, ≥ 1.
- BLINK_PERIOD_MS, 1000: slow blink period in ticks. Must be a multiple of 8 and ≥ 8.
- FLASH_MS, 50: flash stretch length in ticks, ≥ 1.
- ACTIVE_LOW, 0: 1 inverts every LED output (sink-driven LEDs).
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous and active-low.
- mode  in  3*CH  per-channel mode. Channel i uses mode[3i+2:3i].
- event  in  CH  per-channel single-cycle event strobes, used by FLASH mode only.
- led  out  CH  registered LED drive.
- tick  out  1  one-cycle strobe at TICK_HZ, exported for other blocks.

## Operation
- Prescaler: counter pc runs 0..DIV-1 and wraps to 0. tick=1 for exactly the one cycle in which pc==DIV-1; tick is registered.
- Phase counter ph, width clog2(BLINK_PERIOD_MS): increments on tick and wraps from BLINK_PERIOD_MS-1 to 0. Let P = BLINK_PERIOD_MS.
- Mode decode per channel; "on" is the logical lit state:
  - 0 OFF: on=0.
  - 1 ON: on=1.
  - 2 SLOW: on = (ph < P/2).
  - 3 FAST: on = ((ph mod P/4) < P/8). Four pulses per slow period.
  - 4 HEART: on = (ph < P/8) or (P/4 ≤ ph < 3P/8).
  - 5 FLASH: on = (fc_i != 0).
  - 6, 7 reserved: treated as OFF.
- Flash counter fc_i, width clog2(FLASH_MS+1), one per channel:
  - In mode 5, event_i=1 loads FLASH_MS.
  - Otherwise, a tick with fc_i != 0 decrements it.
  - Load beats a decrement when event_i and tick coincide.
  - Retrigger while lit reloads FLASH_MS; pulses do not accumulate.
  - In any mode other than 5, fc_i is forced to 0 and event_i is ignored.
- Output stage: led[i] <= on_i ^ ACTIVE_LOW. Mode changes take effect with no phase reset; blink channels join the shared phase mid-period.
- All state uses a synchronous reset while rst_n=0: pc=0, ph=0, fc=0, tick=0, led = {CH{ACTIVE_LOW}} (all dark).

## Timing
- Reset: sampled on the clk edge; asserting mid-operation darkens all LEDs on the next edge regardless of mode.
- First tick: high in the DIV-th cycle after the first rising edge with rst_n=1. Subsequent ticks occur every DIV cycles.
- Mode/event to led latency: one clk cycle, from the registered output.
- Phase to led latency: ph updates on the edge after tick, and led follows one edge later.
- Flash length: an event with no retrigger keeps led lit for FLASH_MS tick edges, minus the fraction before the first tick. Duration is between (FLASH_MS-1)*DIV+1 and FLASH_MS*DIV cycles.
- Boundary cases:
  - ph wrap from P-1 to 0 is seamless: SLOW/HEART relight on the wrap.
  - FLASH_MS=1 gives a 1..DIV cycle flash.
  - An event held high continuously keeps the flash lit indefinitely.
  - Several channels may flash simultaneously, independently.

## Test plan
Bench parameters: CLK_HZ=10_000, TICK_HZ=1000 (DIV=10), CH=4, BLINK_PERIOD_MS=16, FLASH_MS=5.
- Reset/tick: hold rst_n=0 for 5 cycles with all modes=1, ACTIVE_LOW=0 -> led=4'b0000 and tick=0 during reset. led=4'b1111 one cycle after release. First tick in cycle 10 after release, then every 10 cycles.
- Blink modes: ch0=SLOW, ch1=FAST, ch2=HEART -> ch0 period 160 cycles, 80 high. ch1 period 40, 20 high. ch2 high for ph∈{0,1,4,5}, i.e. two 20-cycle pulses per 160 cycles. All rising edges aligned at the ph wrap.
- Flash: ch3=FLASH, one event pulse -> led[3] high the next cycle, dark after the 5th subsequent tick. Retrigger at the 3rd tick -> dark only after 5 further ticks. Event coinciding with a tick -> fc reads 5, not 4.
- Mode edge cases: event pulses on ch0 in SLOW -> no effect. Mode 7 -> led dark. Switching FLASH->OFF mid-flash -> dark next cycle, and a later switch back to FLASH stays dark until an event.
- Polarity/reset mid-run: ACTIVE_LOW=1, mode=ON -> led=0. Assert rst_n mid-blink -> led=4'b1111 next edge, and ph restarts from 0 after release.
